// File: rtl/qspi_bus_arbiter_if.sv
// Signal bundle between the on-chip QSPI requesters and the bus arbiter.
// The master side drives requests and control; the slave side is the arbiter.
interface qspi_bus_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic               en_i;
  logic [NUM_REQ-1:0] req_i;
  logic               tmo_clr_i;
  logic [NUM_REQ-1:0] gnt_o;
  logic [IDX_W-1:0]   gnt_idx_o;
  logic               busy_o;
  logic [NUM_REQ-1:0] csn_o;
  logic               tmo_pulse_o;
  logic               tmo_flag_o;
  logic [IDX_W-1:0]   tmo_idx_o;

  modport master (
    output en_i, req_i, tmo_clr_i,
    input  gnt_o, gnt_idx_o, busy_o, csn_o, tmo_pulse_o, tmo_flag_o, tmo_idx_o
  );

  modport slave (
    input  en_i, req_i, tmo_clr_i,
    output gnt_o, gnt_idx_o, busy_o, csn_o, tmo_pulse_o, tmo_flag_o, tmo_idx_o
  );
endinterface

// File: rtl/qspi_bus_arbiter.sv
// Round-robin owner arbitration for the shared QSPI master, with a CS-high gap
// between owners and forced revocation of owners that hold the bus too long.
module qspi_bus_arbiter #(
  parameter int               NUM_REQ = 4,
  parameter int               GAP_CYC = 2,
  parameter int               TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'hFFFF
) (
  input logic               clk_i,
  input logic               rst_i,
  qspi_bus_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam state_t RELEASE_ST = (GAP_CYC > 0) ? GAP : IDLE;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               flag_q, flag_d;
  logic [IDX_W-1:0]   tmo_idx_q, tmo_idx_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   pick;

  // First eligible index after the last owner, wrapping; the lowest offset wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] last,
                                               input logic [NUM_REQ-1:0] elig_v);
    logic [IDX_W-1:0] sel;
    int p;
    sel = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      p = (int'(last) + k) % NUM_REQ;
      if (elig_v[p[IDX_W-1:0]]) sel = p[IDX_W-1:0];
    end
    return sel;
  endfunction

  assign elig = bus.req_i & ~mask_q;
  assign pick = rr_pick(last_q, elig);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      flag_q    <= 1'b0;
      tmo_idx_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      flag_q    <= flag_d;
      tmo_idx_q <= tmo_idx_d;
      mask_q    <= mask_d;
    end
  end

  // cnt_q times the grant in GRANT and is reused as the gap timer in GAP.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    flag_d    = flag_q & ~bus.tmo_clr_i;
    tmo_idx_d = tmo_idx_q;
    mask_d    = mask_q & bus.req_i;

    case (state_q)
      IDLE: begin
        if (bus.en_i && (elig != '0)) begin
          gnt_d     = NUM_REQ'(1) << pick;
          gnt_idx_d = pick;
          last_d    = pick;
          cnt_d     = '0;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        if (cnt_q != '1) cnt_d = cnt_q + TMO_W'(1);
        if (!bus.req_i[gnt_idx_q]) begin
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = RELEASE_ST;
        end else if ((TMO_CYC != '0) && (cnt_q == TMO_CYC - TMO_W'(1))) begin
          // Set has priority over a same-cycle tmo_clr_i.
          gnt_d             = '0;
          cnt_d             = '0;
          pulse_d           = 1'b1;
          flag_d            = 1'b1;
          tmo_idx_d         = gnt_idx_q;
          mask_d[gnt_idx_q] = 1'b1;
          state_d           = RELEASE_ST;
        end
      end
      GAP: begin
        if (cnt_q == TMO_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.csn_o       = ~gnt_q;
  assign bus.gnt_idx_o   = gnt_idx_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.tmo_pulse_o = pulse_q;
  assign bus.tmo_flag_o  = flag_q;
  assign bus.tmo_idx_o   = tmo_idx_q;
endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: directed vector table, hand-written timing
// sequences, then random traffic compared against an owner-level reference model.
module tb_qspi_bus_arbiter;
  localparam int NUM_REQ = 4;
  localparam int GAP_CYC = 2;
  localparam int TMO_CYC = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_vectors     = 0;
  int   n_miscompares = 0;

  always #5 clk = ~clk;

  qspi_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  qspi_bus_arbiter #(
    .NUM_REQ(NUM_REQ),
    .GAP_CYC(GAP_CYC),
    .TMO_W  (16),
    .TMO_CYC(16'(TMO_CYC))
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Reference model: who owns the bus, how long, and how much gap is left.
  typedef struct {
    int       owner;
    int       hold;
    int       gap;
    int       last;
    int       gnt_idx;
    int       tmo_idx;
    bit       pulse;
    bit       flag;
    bit [3:0] mask;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1; r.hold = 0; r.gap = 0; r.last = NUM_REQ - 1;
    r.gnt_idx = 0; r.tmo_idx = 0; r.pulse = 1'b0; r.flag = 1'b0; r.mask = 4'b0;
    return r;
  endfunction

  function automatic model_t model_next(model_t s, logic r, logic en, logic clr, logic [3:0] req);
    model_t n;
    int c;
    if (r) return model_reset();
    n       = s;
    n.pulse = 1'b0;
    n.flag  = s.flag && !clr;
    n.mask  = s.mask & req;
    if (s.owner >= 0) begin
      n.hold = s.hold + 1;
      if (!req[s.owner[1:0]]) begin
        n.owner = -1;
        n.gap   = GAP_CYC;
      end else if (n.hold >= TMO_CYC) begin
        n.pulse = 1'b1;
        n.flag  = 1'b1;
        n.tmo_idx = s.owner;
        n.mask[s.owner[1:0]] = 1'b1;
        n.owner = -1;
        n.gap   = GAP_CYC;
      end
    end else if (s.gap > 0) begin
      n.gap = s.gap - 1;
    end else if (en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (s.last + k) % NUM_REQ;
        if (req[c[1:0]] && !s.mask[c[1:0]]) begin
          n.owner = c; n.hold = 0; n.last = c; n.gnt_idx = c;
          break;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, bus.en_i, bus.tmo_clr_i, bus.req_i);

  typedef struct {
    bit       rst;
    bit       en;
    bit       clr;
    bit [3:0] req;
    bit [3:0] gnt;
    bit       busy;
    bit [1:0] idx;
    bit       pulse;
    bit       flag;
  } vec_t;

  task automatic applyStimulus(input logic r, input logic en, input logic [3:0] req, input logic clr);
    rst           = r;
    bus.en_i      = en;
    bus.req_i     = req;
    bus.tmo_clr_i = clr;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_gnt, input logic e_busy,
                             input logic [1:0] e_idx, input logic e_pulse, input logic e_flag,
                             input logic [1:0] e_tidx);
    n_vectors++;
    if (bus.gnt_o !== e_gnt || bus.csn_o !== ~e_gnt || bus.busy_o !== e_busy ||
        bus.gnt_idx_o !== e_idx || bus.tmo_pulse_o !== e_pulse ||
        bus.tmo_flag_o !== e_flag || bus.tmo_idx_o !== e_tidx) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got gnt=%b csn=%b busy=%b idx=%0d pulse=%b flag=%b tidx=%0d, want gnt=%b csn=%b busy=%b idx=%0d pulse=%b flag=%b tidx=%0d",
               name, bus.gnt_o, bus.csn_o, bus.busy_o, bus.gnt_idx_o, bus.tmo_pulse_o,
               bus.tmo_flag_o, bus.tmo_idx_o, e_gnt, ~e_gnt, e_busy, e_idx, e_pulse, e_flag, e_tidx);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Holds requester 2 until revoked; optionally pulses tmo_clr_i on the revoke cycle.
  task automatic tmoRun(input bit with_clr);
    int hi;
    hi = 1;
    while (hi < 20) begin
      @(negedge clk);
      if (bus.gnt_o == 4'b0100) hi++;
      else break;
      if (with_clr && hi == TMO_CYC) bus.tmo_clr_i = 1'b1;
    end
    bus.tmo_clr_i = 1'b0;
    checkValue(with_clr ? "tmo2_len" : "tmo_len", hi, TMO_CYC);
    checkValue(with_clr ? "tmo2_pulse" : "tmo_pulse", bus.tmo_pulse_o, 1);
    checkValue(with_clr ? "tmo2_flag_set_wins" : "tmo_flag", bus.tmo_flag_o, 1);
    checkValue(with_clr ? "tmo2_idx" : "tmo_idx", bus.tmo_idx_o, 2);
    @(negedge clk);
    checkValue("tmo_pulse_single", bus.tmo_pulse_o, 0);
    checkValue("tmo_flag_sticky", bus.tmo_flag_o, 1);
  endtask

  initial begin
    vec_t     tbl[17];
    int       waited;
    bit       seen;
    logic [3:0] exp4, csn4;

    tbl[0]  = '{1, 1, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, 0};
    tbl[1]  = '{0, 1, 0, 4'b0001, 4'b0001, 1, 2'd0, 0, 0};
    tbl[2]  = '{0, 1, 0, 4'b0001, 4'b0001, 1, 2'd0, 0, 0};
    tbl[3]  = '{0, 1, 0, 4'b0000, 4'b0000, 1, 2'd0, 0, 0};
    tbl[4]  = '{0, 1, 0, 4'b0000, 4'b0000, 1, 2'd0, 0, 0};
    tbl[5]  = '{0, 1, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, 0};
    tbl[6]  = '{0, 1, 0, 4'b0010, 4'b0010, 1, 2'd1, 0, 0};
    tbl[7]  = '{0, 0, 0, 4'b1010, 4'b0010, 1, 2'd1, 0, 0};
    tbl[8]  = '{0, 0, 0, 4'b1000, 4'b0000, 1, 2'd1, 0, 0};
    tbl[9]  = '{0, 0, 0, 4'b1000, 4'b0000, 1, 2'd1, 0, 0};
    tbl[10] = '{0, 0, 0, 4'b1000, 4'b0000, 0, 2'd1, 0, 0};
    tbl[11] = '{0, 0, 0, 4'b1000, 4'b0000, 0, 2'd1, 0, 0};
    tbl[12] = '{0, 1, 0, 4'b1000, 4'b1000, 1, 2'd3, 0, 0};
    tbl[13] = '{0, 1, 0, 4'b1000, 4'b1000, 1, 2'd3, 0, 0};
    tbl[14] = '{1, 1, 0, 4'b1000, 4'b0000, 0, 2'd0, 0, 0};
    tbl[15] = '{0, 1, 0, 4'b1111, 4'b0001, 1, 2'd0, 0, 0};
    tbl[16] = '{0, 1, 0, 4'b1111, 4'b0001, 1, 2'd0, 0, 0};

    for (int v = 0; v < 17; v++) begin
      applyStimulus(tbl[v].rst, tbl[v].en, tbl[v].req, tbl[v].clr);
      @(negedge clk);
      checkOutput($sformatf("table[%0d]", v), tbl[v].gnt, tbl[v].busy, tbl[v].idx,
                  tbl[v].pulse, tbl[v].flag, 2'd0);
    end

    // Round robin with all four requesting, each owner releasing after 5 cycles.
    applyStimulus(1, 1, 4'b0000, 0);
    @(negedge clk);
    applyStimulus(0, 1, 4'b1111, 0);
    for (int n = 0; n < 5; n++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
        if (waited == 1 && n > 0) bus.req_i = 4'b1111;
      end while (bus.gnt_o == 4'b0000 && waited < 20);
      exp4 = 4'b0001 << (n % NUM_REQ);
      csn4 = ~exp4;
      checkValue($sformatf("rr_order[%0d]", n), bus.gnt_o, exp4);
      checkValue($sformatf("rr_csn[%0d]", n), bus.csn_o, csn4);
      checkValue($sformatf("rr_gap[%0d]", n), waited - 1, (n == 0) ? 0 : GAP_CYC + 1);
      repeat (4) @(negedge clk);
      checkValue($sformatf("rr_hold[%0d]", n), bus.gnt_o, exp4);
      bus.req_i[n % NUM_REQ] = 1'b0;
    end

    // Timeout on requester 2, masking until it drops, then clear/set collision.
    applyStimulus(1, 1, 4'b0000, 0);
    @(negedge clk);
    applyStimulus(0, 1, 4'b0100, 0);
    @(negedge clk);
    checkValue("tmo_grant_latency", bus.gnt_o, 4'b0100);
    tmoRun(1'b0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.gnt_o != 4'b0000) seen = 1'b1;
    end
    checkValue("tmo_no_regrant", seen, 0);
    bus.req_i = 4'b0000;
    @(negedge clk);
    bus.req_i = 4'b0100;
    @(negedge clk);
    checkValue("tmo_regrant", bus.gnt_o, 4'b0100);
    tmoRun(1'b1);
    bus.tmo_clr_i = 1'b1;
    @(negedge clk);
    bus.tmo_clr_i = 1'b0;
    checkValue("tmo_flag_cleared", bus.tmo_flag_o, 0);

    // Random traffic against the reference model.
    applyStimulus(1, 1, 4'b0000, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rand[%0d]", i),
                  (m.owner >= 0) ? (4'b0001 << m.owner) : 4'b0000,
                  (m.owner >= 0) || (m.gap > 0), m.gnt_idx[1:0], m.pulse, m.flag,
                  m.tmo_idx[1:0]);
      rst           = ($urandom_range(99) == 0);
      bus.en_i      = ($urandom_range(9) != 0);
      bus.tmo_clr_i = ($urandom_range(19) == 0);
      for (int b = 0; b < NUM_REQ; b++)
        if ($urandom_range(7) == 0) bus.req_i[b] = ~bus.req_i[b];
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
